// File: rtl/bin_cnt_pkg.sv
// Shared definitions for the binary counter and its monitor.
// Holds the default counter width and the monitor FSM state encoding.
package bin_cnt_pkg;

    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } mon_state_t;

endpackage

// File: rtl/bin_cnt_mon_sat_cnt.sv
// Saturating event counter with a sticky saturation flag.
// Ports: clk, rst (async, active-high), inc, value, sat.
module sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         sat
);

    localparam logic [W-1:0] ONE = 1;
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] nxt;

    assign nxt = value + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (inc && value != MAX) begin
            value <= nxt;
            // Flag goes up on the same edge the count hits max
            if (nxt == MAX)
                sat <= 1'b1;
        end
    end

endmodule

// File: rtl/bin_cnt_mon.sv
// Monitor checking that an upstream counter advances by +1 every clock.
// Ports: clk, rst, counter in; locked, wrap/restart/err pulses, counts out.
module bin_cnt_mon
    import bin_cnt_pkg::*;
#(
    parameter int WIDTH    = CNT_WIDTH,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4,
    parameter int SYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  counter,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              restart_pulse,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic              err_sat
);

    localparam logic [WIDTH-1:0]  ONE  = 1;
    localparam logic [WIDTH-1:0]  MAXV = '1;
    localparam logic [WRAP_W-1:0] WONE = 1;
    localparam logic [3:0]        SLEN = 4'(SYNC_LEN);

    mon_state_t       state;
    logic [WIDTH-1:0] prev;
    logic [2:0]       run;
    logic [3:0]       runp1;

    logic good;
    logic wrap;
    logic restart;
    logic err_ev;

    always_comb begin
        good    = (counter == prev + ONE);
        wrap    = good && (prev == MAXV);
        // max->0 is good, so it can never land here
        restart = !good && (counter == '0);
        err_ev  = (state == ST_LOCK) && !good && !restart;
        runp1   = {1'b0, run} + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            prev          <= '0;
            run           <= '0;
            locked        <= 1'b0;
            wrap_pulse    <= 1'b0;
            restart_pulse <= 1'b0;
            err_pulse     <= 1'b0;
            wrap_count    <= '0;
        end else begin
            prev          <= counter;
            wrap_pulse    <= 1'b0;
            restart_pulse <= 1'b0;
            err_pulse     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    state <= ST_SYNC;
                    run   <= '0;
                end
                ST_SYNC: begin
                    if (!good) begin
                        run <= '0;
                    end else if (runp1 == SLEN) begin
                        state  <= ST_LOCK;
                        locked <= 1'b1;
                        run    <= '0;
                    end else begin
                        run <= runp1[2:0];
                    end
                end
                ST_LOCK: begin
                    if (wrap) begin
                        wrap_pulse <= 1'b1;
                        wrap_count <= wrap_count + WONE;
                    end else if (good) begin
                        state <= ST_LOCK;
                    end else begin
                        restart_pulse <= restart;
                        err_pulse     <= !restart;
                        state         <= ST_SYNC;
                        run           <= '0;
                        locked        <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    run    <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    sat_cnt #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (err_ev),
        .value(err_count),
        .sat  (err_sat)
    );

endmodule
